// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states and instruction field positions.
package mips_pkg;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } fetch_state_t;

   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam int JT_HI    = 25;
   localparam int JT_LO    = 0;

   function automatic logic [5:0] instr_op(input logic [31:0] i);
      return i[OP_HI:OP_LO];
   endfunction

   function automatic logic [5:0] instr_funct(input logic [31:0] i);
      return i[FUNCT_HI:FUNCT_LO];
   endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for a retiring instruction; jump beats branch beats sequential.
module pc_next
   import mips_pkg::*;
(
   input  logic [31:0] pcplus4,
   input  logic [31:0] instr,
   input  logic        pcsrc,
   input  logic        jump,
   output logic [31:0] pcnext
);

   logic [31:0] jtarget;
   logic [31:0] btarget;
   logic        unused_op;

   // The opcode field carries no address information.
   assign unused_op = ^instr[OP_HI:OP_LO];

   assign jtarget = {pcplus4[31:28], instr[JT_HI:JT_LO], 2'b00};
   assign btarget = pcplus4 + {{14{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO], 2'b00};

   always_comb begin
      pcnext = pcplus4;
      if (jump)
         pcnext = jtarget;
      else if (pcsrc)
         pcnext = btarget;
   end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: PC, request/ack fetch FSM, instruction register
// and retired-instruction counter.
module ifetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pcplus4,
   input  logic        retire,
   input  logic        pcsrc,
   input  logic        jump,
   output logic [31:0] instret
);

   fetch_state_t state, state_n;
   logic         rst_q;
   logic         fetch_go;
   logic         retire_go;
   logic [31:0]  npc;

   // rst_q masks the request for the cycle after a reset edge without a
   // combinational path from reset; a stale ack in that cycle is dropped.
   always_ff @(posedge clk) begin
      rst_q <= reset;
      if (reset)
         state <= FETCH;
      else
         state <= state_n;
   end

   assign fetch_go  = (state == FETCH) && !rst_q && imem_ack;
   assign retire_go = (state == EXEC) && retire;

   always_comb begin
      state_n = state;
      case (state)
         FETCH:   if (fetch_go)  state_n = EXEC;
         EXEC:    if (retire_go) state_n = FETCH;
         default: state_n = FETCH;
      endcase
   end

   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state)
         FETCH:   imem_req    = !rst_q;
         EXEC:    instr_valid = 1'b1;
         default: ;
      endcase
   end

   assign pcplus4   = pc + 32'd4;
   assign imem_addr = pc;

   pc_next u_pc_next (
      .pcplus4 (pcplus4),
      .instr   (instr),
      .pcsrc   (pcsrc),
      .jump    (jump),
      .pcnext  (npc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_PC;
         instr   <= 32'd0;
         instret <= 32'd0;
      end else begin
         if (fetch_go)
            instr <= imem_rdata;
         if (retire_go) begin
            pc      <= npc;
            instret <= instret + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: lockstep stimulus on the falling edge,
// fetched words tracked through a scoreboard queue.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pcplus4;
   logic        retire;
   logic        pcsrc;
   logic        jump;
   logic [31:0] instret;

   ifetch #(.RESET_PC(32'h0000_0040)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pcplus4     (pcplus4),
      .retire      (retire),
      .pcsrc       (pcsrc),
      .jump        (jump),
      .instret     (instret)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;
   logic [31:0] exp_ir;

   task automatic step();
      @(negedge clk);
   endtask

   // One full instruction: fetch with `waits` wait states, `hold` EXEC cycles
   // without retire (pcsrc/jump driven), then retire and check the new PC.
   task automatic do_instr(input logic [31:0] word, input int waits, input int hold,
                           input logic ps, input logic jp, input logic [31:0] exp_next);
      logic [31:0] w;
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || pcplus4 !== exp_pc + 32'd4) begin
         n_err++;
         $display("FAIL fetch_req: req=%b addr=%h pc4=%h required req=1 addr=%h pc4=%h",
                  imem_req, imem_addr, pcplus4, exp_pc, exp_pc + 32'd4);
      end
      for (int i = 0; i < waits; i++) begin
         imem_ack = 1'b0;
         step();
         n_cmp++;
         if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wait_hold: req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
                     imem_req, imem_addr, instr_valid, exp_pc);
         end
      end
      imem_ack = 1'b1;
      imem_rdata = word;
      exp_q.push_back(word);
      step();
      imem_ack = 1'b0;
      imem_rdata = 32'hBAD0_BAD0;
      w = exp_q.pop_front();
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== w) begin
         n_err++;
         $display("FAIL instr_word: valid=%b instr=%h required valid=1 instr=%h",
                  instr_valid, instr, w);
      end
      for (int i = 0; i < hold; i++) begin
         pcsrc = ps;
         jump = jp;
         step();
         n_cmp++;
         if (pc !== exp_pc || instr_valid !== 1'b1 || instr !== w || instret !== exp_ir) begin
            n_err++;
            $display("FAIL no_retire_hold: pc=%h valid=%b instr=%h instret=%0d required pc=%h valid=1 instr=%h instret=%0d",
                     pc, instr_valid, instr, instret, exp_pc, w, exp_ir);
         end
      end
      retire = 1'b1;
      pcsrc = ps;
      jump = jp;
      step();
      retire = 1'b0;
      pcsrc = 1'b0;
      jump = 1'b0;
      exp_ir = exp_ir + 32'd1;
      exp_pc = exp_next;
      n_cmp++;
      if (pc !== exp_pc || imem_req !== 1'b1 || instr_valid !== 1'b0 || instret !== exp_ir) begin
         n_err++;
         $display("FAIL next_pc: pc=%h req=%b valid=%b instret=%0d required pc=%h req=1 valid=0 instret=%0d",
                  pc, imem_req, instr_valid, instret, exp_pc, exp_ir);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      imem_ack = 1'b0;
      imem_rdata = 32'd0;
      retire = 1'b0;
      pcsrc = 1'b0;
      jump = 1'b0;
      step();
      step();
      n_cmp++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h40 ||
          instr !== 32'd0 || instret !== 32'd0) begin
         n_err++;
         $display("FAIL reset_state: req=%b valid=%b pc=%h instr=%h instret=%0d required 0 0 00000040 0 0",
                  imem_req, instr_valid, pc, instr, instret);
      end
      reset = 1'b0;
      step();
      exp_pc = 32'h40;
      exp_ir = 32'd0;
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         n_err++;
         $display("FAIL first_req: req=%b addr=%h required req=1 addr=00000040", imem_req, imem_addr);
      end
   endtask

   task automatic test_sequential();
      time t0;
      t0 = $time;
      do_instr(32'h2001_0001, 0, 0, 1'b0, 1'b0, 32'h44);
      do_instr(32'h2002_0002, 0, 0, 1'b0, 1'b0, 32'h48);
      do_instr(32'h2003_0003, 0, 0, 1'b0, 1'b0, 32'h4C);
      n_cmp++;
      if (($time - t0) !== 60 || instret !== 32'd3) begin
         n_err++;
         $display("FAIL seq_throughput: elapsed=%0t instret=%0d required elapsed=60 instret=3",
                  $time - t0, instret);
      end
   endtask

   task automatic test_wait_states();
      do_instr(32'h8C22_0010, 3, 0, 1'b0, 1'b0, 32'h50);
   endtask

   task automatic test_branch();
      do_instr(32'h0800_0040, 0, 0, 1'b0, 1'b1, 32'h100);
      do_instr(32'h1000_FFFE, 0, 5, 1'b1, 1'b0, 32'hFC);
   endtask

   task automatic test_spurious_wrap();
      logic [31:0] w;
      do_instr(32'h1000_FFC0, 0, 0, 1'b1, 1'b0, 32'h0);
      do_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFFC);
      // retire while fetching must be ignored
      retire = 1'b1;
      step();
      retire = 1'b0;
      n_cmp++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || pc !== exp_pc || instret !== exp_ir) begin
         n_err++;
         $display("FAIL spurious_retire: req=%b valid=%b pc=%h instret=%0d required req=1 valid=0 pc=%h instret=%0d",
                  imem_req, instr_valid, pc, instret, exp_pc, exp_ir);
      end
      imem_ack = 1'b1;
      imem_rdata = 32'h2404_0004;
      exp_q.push_back(32'h2404_0004);
      step();
      w = exp_q.pop_front();
      imem_rdata = 32'hFFFF_FFFF;
      step();
      imem_ack = 1'b0;
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== w || pc !== exp_pc || instret !== exp_ir) begin
         n_err++;
         $display("FAIL spurious_ack: valid=%b instr=%h pc=%h instret=%0d required valid=1 instr=%h pc=%h instret=%0d",
                  instr_valid, instr, pc, instret, w, exp_pc, exp_ir);
      end
      retire = 1'b1;
      step();
      retire = 1'b0;
      exp_pc = 32'h0;
      exp_ir = exp_ir + 32'd1;
      n_cmp++;
      if (pc !== 32'h0 || imem_req !== 1'b1 || instret !== exp_ir) begin
         n_err++;
         $display("FAIL pc_wrap: pc=%h req=%b instret=%0d required pc=00000000 req=1 instret=%0d",
                  pc, imem_req, instret, exp_ir);
      end
   endtask

   task automatic test_jump_priority();
      do_instr(32'h0BFF_FFFF, 0, 0, 1'b0, 1'b1, 32'h0FFF_FFFC);
      do_instr(32'h0800_0000, 1, 0, 1'b0, 1'b1, 32'h1000_0000);
      do_instr(32'h0800_0010, 0, 0, 1'b1, 1'b1, 32'h1000_0040);
   endtask

   task automatic test_reset_mid();
      imem_ack = 1'b1;
      imem_rdata = 32'h2005_0005;
      step();
      imem_ack = 1'b0;
      reset = 1'b1;
      retire = 1'b1;
      step();
      reset = 1'b0;
      retire = 1'b0;
      n_cmp++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h40 || instret !== 32'd0) begin
         n_err++;
         $display("FAIL reset_exec: req=%b valid=%b pc=%h instret=%0d required req=0 valid=0 pc=00000040 instret=0",
                  imem_req, instr_valid, pc, instret);
      end
      step();
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         n_err++;
         $display("FAIL reset_recover: req=%b addr=%h required req=1 addr=00000040", imem_req, imem_addr);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++;
      if (imem_req !== 1'b0) begin
         n_err++;
         $display("FAIL reset_fetch_req: req=%b required req=0", imem_req);
      end
      // late ack for the abandoned request
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      n_cmp++;
      if (instr_valid !== 1'b0 || instr !== 32'd0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         n_err++;
         $display("FAIL late_ack: valid=%b instr=%h req=%b addr=%h required valid=0 instr=00000000 req=1 addr=00000040",
                  instr_valid, instr, imem_req, imem_addr);
      end
      exp_pc = 32'h40;
      exp_ir = 32'd0;
      do_instr(32'h2006_0006, 1, 0, 1'b0, 1'b0, 32'h44);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wait_states();
      test_branch();
      test_spurious_wrap();
      test_jump_priority();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
